// File: rtl/rt4_dec_if.sv
// Request/response bundle for the round-4 decrypt unit: start/done handshake,
// captured operands and registered results.
interface rt4_dec_if;
    logic         start;
    logic [511:0] t4;
    logic [127:0] c1;
    logic [127:0] z0;
    logic         busy;
    logic         done;
    logic [127:0] m1;
    logic [511:0] state_out;

    modport master (output start, t4, c1, z0, input busy, done, m1, state_out);
    modport slave  (input start, t4, c1, z0, output busy, done, m1, state_out);
endinterface

// File: rtl/rt4_dec.sv
// Round-4 decrypt: recovers m1 and the post-round state using one shared AES round.
// Latency 3 cycles from start acceptance; new start taken only in IDLE, never queued.
module rt4_dec (
    input  logic     clk,
    input  logic     rst,
    rt4_dec_if.slave io
);
    typedef enum logic [1:0] {IDLE, RND1, RND2, FIN} state_t;

    // Element 255 is S(0x00); indexing with the inverted byte keeps the table in FIPS reading order.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes are MSB-first: row 0 in bits [31:24].
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    state_t       st;
    logic [511:0] t4_q;
    logic [127:0] c1_q;
    logic [127:0] z0_q;
    logic [127:0] a_q;
    logic [127:0] b_q;
    logic [127:0] m1_q;
    logic [511:0] so_q;
    logic         done_q;
    logic         busy_q;

    // Word 0 occupies the top of every 512-bit vector, byte 0 the top of every word.
    logic [127:0] w0, w1, w2, w3;
    assign w0 = t4_q[511:384];
    assign w1 = t4_q[383:256];
    assign w2 = t4_q[255:128];
    assign w3 = t4_q[127:0];

    logic [127:0] rnd_in;
    logic [127:0] rnd_key;
    logic [127:0] rnd_out;
    logic [31:0]  col;

    always_comb begin
        rnd_in  = (st == RND1) ? w3 : w0;
        rnd_key = (st == RND2) ? z0_q : '0;
        rnd_out = '0;
        col     = '0;
        for (int c = 0; c < 4; c++) begin
            // ShiftRows folded into the S-box fetch: row r of column c reads column (c+r)%4.
            for (int r = 0; r < 4; r++) begin
                col[31-8*r -: 8] = SBOX[~rnd_in[127-8*(r+4*((c+r)%4)) -: 8]];
            end
            rnd_out[127-32*c -: 32] = mix_col(col) ^ rnd_key[127-32*c -: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            t4_q   <= '0;
            c1_q   <= '0;
            z0_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            m1_q   <= '0;
            so_q   <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (st)
                IDLE: begin
                    // busy stays up through the done cycle and drops on the following edge.
                    busy_q <= io.start;
                    if (io.start) begin
                        t4_q <= io.t4;
                        c1_q <= io.c1;
                        z0_q <= io.z0;
                        st   <= RND1;
                    end
                end
                RND1: begin
                    a_q <= rnd_out;
                    st  <= RND2;
                end
                RND2: begin
                    b_q <= rnd_out;
                    st  <= FIN;
                end
                FIN: begin
                    m1_q   <= c1_q ^ a_q ^ w0;
                    so_q   <= {c1_q, b_q, w1, w2};
                    done_q <= 1'b1;
                    st     <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign io.busy      = busy_q;
    assign io.done      = done_q;
    assign io.m1        = m1_q;
    assign io.state_out = so_q;
endmodule

// File: tb/tb_rt4_dec.sv
// Directed and round-trip checks for rt4_dec, with an independently derived AES round model.
module tb_rt4_dec;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    rt4_dec_if io ();
    rt4_dec dut (.clk(clk), .rst(rst), .io(io));

    always #5 clk = ~clk;

    logic [7:0] sbx [256];

    localparam logic [127:0] FV  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FK  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FB  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] FM  = 128'h1d5b625b403ffbb1d23e5e50c1fe6e44;
    localparam logic [127:0] FC  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] FW1 = 128'h11111111222222223333333344444444;
    localparam logic [127:0] FW2 = 128'h55555555666666667777777788888888;
    localparam logic [127:0] B63 = {16{8'h63}};

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int u = 1; u < 256; u++)
                if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
            sbx[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_r(input logic [127:0] x, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) s[i] = sbx[x[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = s[r + 4*((c+r)%4)];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                y[127-8*(r+4*c) -: 8] = gmul(8'h02, t[r+4*c]) ^ gmul(8'h03, t[(r+1)%4+4*c])
                                      ^ t[(r+2)%4+4*c] ^ t[(r+3)%4+4*c];
        return y ^ k;
    endfunction

    // Encrypt-side round: produces the ciphertext word and the post-round state.
    function automatic logic [511:0] enc(input logic [511:0] t, input logic [127:0] m, input logic [127:0] z);
        logic [127:0] c;
        c = m ^ aes_r(t[127:0], '0) ^ t[511:384];
        return {c, aes_r(t[511:384], z), t[383:256], t[255:128]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // mode 0: plain; 1: scramble inputs while busy; 2: pulse start in RND1/RND2/FIN.
    task automatic run_op(input string tag, input logic [511:0] t, input logic [127:0] c,
                          input logic [127:0] z, input int mode,
                          input logic [127:0] exp_m1, input logic [511:0] exp_so);
        int lat;
        @(negedge clk);
        io.t4 = t;
        io.c1 = c;
        io.z0 = z;
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        lat = -1;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            if (io.done) lat = k;
            else begin
                io.start = (mode == 2);
                if (mode == 1) begin
                    io.t4 = {rnd128(), rnd128(), rnd128(), rnd128()};
                    io.c1 = rnd128();
                    io.z0 = rnd128();
                end
                @(negedge clk);
            end
        end
        io.start = 1'b0;
        chk({tag, "_latency"}, 512'(lat), 512'd3);
        chk({tag, "_m1"}, 512'(io.m1), 512'(exp_m1));
        chk({tag, "_state_out"}, io.state_out, exp_so);
        chk({tag, "_busy_at_done"}, 512'(io.busy), 512'd1);
        @(negedge clk);
        chk({tag, "_idle_after"}, 512'({io.busy, io.done}), 512'd0);
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (io.done) cnt++;
        end
    endtask

    initial begin
        logic [11:0]  dv;
        logic [11:0]  bv;
        logic [511:0] t;
        logic [511:0] e;
        logic [127:0] m;
        logic [127:0] z;
        int           cnt;

        build_sbox();
        rst = 1'b1;
        io.start = 1'b0;
        io.t4 = '0;
        io.c1 = '0;
        io.z0 = '0;
        repeat (3) @(negedge clk);
        chk("rst_m1", 512'(io.m1), 512'd0);
        chk("rst_state_out", io.state_out, 512'd0);
        chk("rst_done", 512'(io.done), 512'd0);
        chk("rst_busy", 512'(io.busy), 512'd0);
        rst = 1'b0;

        run_op("zero", '0, '0, '0, 0, B63, {128'h0, B63, 256'h0});
        run_op("keyed", '0, '0, {128{1'b1}}, 0, B63, {128'h0, {16{8'h9c}}, 256'h0});
        run_op("keyless_ff", {384'h0, {128{1'b1}}}, '0, '0, 0, {16{8'h16}}, {128'h0, B63, 256'h0});
        run_op("fips", {FV, FW1, FW2, FV}, FC, FK, 0, FC ^ FM, {FC, FB, FW1, FW2});
        run_op("scramble", '0, '0, '0, 1, B63, {128'h0, B63, 256'h0});

        run_op("poke", '0, '0, {128{1'b1}}, 2, B63, {128'h0, {16{8'h9c}}, 256'h0});
        count_done(6, cnt);
        chk("poke_no_extra_done", 512'(cnt), 512'd0);
        chk("poke_m1_held", 512'(io.m1), 512'(B63));

        // Continuous start: acceptances every 4 cycles, busy never drops.
        @(negedge clk);
        io.t4 = {FV, FW1, FW2, FV};
        io.c1 = FC;
        io.z0 = FK;
        io.start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            dv[k] = io.done;
            bv[k] = io.busy;
            @(negedge clk);
        end
        io.start = 1'b0;
        chk("cont_done_pattern", 512'(dv), 512'h888);
        chk("cont_busy_pattern", 512'(bv), 512'hfff);
        chk("cont_m1", 512'(io.m1), 512'(FC ^ FM));
        repeat (6) @(negedge clk);

        // Reset asserted while the unit sits in RND2.
        io.t4 = {FV, FW1, FW2, FV};
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_m1", 512'(io.m1), 512'd0);
        chk("midrst_state_out", io.state_out, 512'd0);
        chk("midrst_busy_done", 512'({io.busy, io.done}), 512'd0);
        rst = 1'b0;
        count_done(6, cnt);
        chk("midrst_no_done", 512'(cnt), 512'd0);
        run_op("after_rst", '0, '0, '0, 0, B63, {128'h0, B63, 256'h0});

        for (int n = 0; n < 1000; n++) begin
            t = {rnd128(), rnd128(), rnd128(), rnd128()};
            m = rnd128();
            z = rnd128();
            e = enc(t, m, z);
            run_op("roundtrip", t, e[511:384], z, 0, m, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, failed so far %0d", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
